// File: rtl/netwalk_tcam_program_ctrl.sv
// rtl/netwalk_tcam_program_ctrl.sv - TCAM entry program/delete sequencer with per-entry valid bitmap
// Commands run IDLE -> SETUP -> WRITE (held) -> DONE; an out-of-range unit skips straight to DONE with an error.
module netwalk_tcam_program_ctrl #(
  parameter int DPL_MATCH_FIELD_WIDTH = 356,
  parameter int TCAM_ADDR_WIDTH       = 6,
  parameter int TCAM_UNIT_SEL_WIDTH   = 2,
  parameter int NUM_TCAM_UNITS        = 4,
  parameter int PROGRAM_HOLD_CYCLES   = 2
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           cmd_valid,
  output logic                                           cmd_ready,
  input  logic                                           cmd_op,
  input  logic [TCAM_UNIT_SEL_WIDTH+TCAM_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DPL_MATCH_FIELD_WIDTH-1:0]               cmd_data,
  input  logic [DPL_MATCH_FIELD_WIDTH-1:0]               cmd_mask,
  output logic [DPL_MATCH_FIELD_WIDTH-1:0]               tcam_program_data,
  output logic [DPL_MATCH_FIELD_WIDTH-1:0]               tcam_program_mask,
  output logic [TCAM_ADDR_WIDTH-1:0]                     tcam_program_addr,
  output logic [NUM_TCAM_UNITS-1:0]                      tcam_unit_sel,
  output logic                                           tcam_program_enable,
  output logic                                           tcam_delete_enable,
  output logic                                           cmd_done,
  output logic                                           cmd_err,
  output logic [TCAM_UNIT_SEL_WIDTH+TCAM_ADDR_WIDTH:0]   entry_count
);

  localparam int FAW         = TCAM_UNIT_SEL_WIDTH + TCAM_ADDR_WIDTH;
  localparam int NUM_ENTRIES = NUM_TCAM_UNITS << TCAM_ADDR_WIDTH;
  localparam int CNT_W       = FAW + 1;
  localparam int HOLD_W      = $clog2(PROGRAM_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_DONE} state_e;

  state_e                           state_q, state_d;
  logic [HOLD_W-1:0]                hold_q, hold_d;
  logic                             op_q, op_d;
  logic [FAW-1:0]                   addr_q, addr_d;
  logic [DPL_MATCH_FIELD_WIDTH-1:0] data_q, data_d, mask_q, mask_d;
  logic [NUM_ENTRIES-1:0]           valid_q, valid_d;
  logic [CNT_W-1:0]                 count_q, count_d;

  logic                             ready_q, ready_d;
  logic [DPL_MATCH_FIELD_WIDTH-1:0] pdata_q, pdata_d, pmask_q, pmask_d;
  logic [TCAM_ADDR_WIDTH-1:0]       paddr_q, paddr_d;
  logic [NUM_TCAM_UNITS-1:0]        sel_q, sel_d;
  logic                             pen_q, pen_d, den_q, den_d;
  logic                             done_q, done_d, err_q, err_d;
  logic                             unit_ok;

  // A fully populated unit space makes every index legal.
  if (NUM_TCAM_UNITS >= (1 << TCAM_UNIT_SEL_WIDTH)) begin : g_all_units
    assign unit_ok = 1'b1;
  end else begin : g_partial_units
    assign unit_ok = cmd_addr[FAW-1:TCAM_ADDR_WIDTH] < TCAM_UNIT_SEL_WIDTH'(NUM_TCAM_UNITS);
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    count_d = count_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          op_d   = cmd_op;
          addr_d = cmd_addr;
          data_d = cmd_data;
          mask_d = cmd_mask;
          if (unit_ok) begin
            state_d = S_SETUP;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_SETUP: begin
        state_d = S_WRITE;
        hold_d  = '0;
      end
      S_WRITE: begin
        if (hold_q == HOLD_W'(PROGRAM_HOLD_CYCLES - 1)) begin
          state_d = S_DONE;
          // Bookkeeping lands on the DONE edge so an aborted write never counts.
          if (op_q) begin
            if (valid_q[addr_q]) begin
              valid_d[addr_q] = 1'b0;
              count_d         = count_q - CNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end else if (!valid_q[addr_q]) begin
            valid_d[addr_q] = 1'b1;
            count_d         = count_q + CNT_W'(1);
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
    pen_d   = (state_d == S_WRITE);
    den_d   = (state_d == S_WRITE) && op_d;
    sel_d   = '0;
    paddr_d = '0;
    pdata_d = '0;
    pmask_d = '0;
    if (state_d == S_SETUP || state_d == S_WRITE) begin
      paddr_d = addr_d[TCAM_ADDR_WIDTH-1:0];
      for (int i = 0; i < NUM_TCAM_UNITS; i++) begin
        sel_d[i] = (addr_d[FAW-1:TCAM_ADDR_WIDTH] == TCAM_UNIT_SEL_WIDTH'(i));
      end
      if (!op_d) begin
        pdata_d = data_d;
        pmask_d = mask_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      valid_q <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      pdata_q <= '0;
      pmask_q <= '0;
      paddr_q <= '0;
      sel_q   <= '0;
      pen_q   <= 1'b0;
      den_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      count_q <= count_d;
      ready_q <= ready_d;
      pdata_q <= pdata_d;
      pmask_q <= pmask_d;
      paddr_q <= paddr_d;
      sel_q   <= sel_d;
      pen_q   <= pen_d;
      den_q   <= den_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready           = ready_q;
  assign tcam_program_data   = pdata_q;
  assign tcam_program_mask   = pmask_q;
  assign tcam_program_addr   = paddr_q;
  assign tcam_unit_sel       = sel_q;
  assign tcam_program_enable = pen_q;
  assign tcam_delete_enable  = den_q;
  assign cmd_done            = done_q;
  assign cmd_err             = err_q;
  assign entry_count         = count_q;

endmodule
